// File: rtl/onchip_ram_burst_adapter.sv
// Avalon-MM burst slave in front of a single-port on-chip RAM: splits read and
// write bursts into one RAM word access per cycle and returns read beats with readdatavalid.
module onchip_ram_burst_adapter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 4,
   parameter int DEPTH   = 12288
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     s_address,
   input  logic [BURST_W-1:0]    s_burstcount,
   input  logic                  s_read,
   input  logic                  s_write,
   input  logic [DATA_W-1:0]     s_writedata,
   input  logic [DATA_W/8-1:0]   s_byteenable,
   output logic                  s_waitrequest,
   output logic [DATA_W-1:0]     s_readdata,
   output logic                  s_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   output logic                  ram_clken,
   input  logic [DATA_W-1:0]     ram_readdata,
   output logic                  wrap_flag
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t               state;
   logic [ADDR_W-1:0]    addr;          // address of the next beat to issue
   logic                 addr_wrapped;  // addr was reached by wrapping from LAST_ADDR
   logic [BURST_W-1:0]   beats_left;    // beats still to issue (RD) or accept (WR)
   logic [BURST_W-1:0]   req_count;
   logic                 accept_wr;
   logic                 accept_rd;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
   endfunction

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      req_count = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
      accept_wr = (state == IDLE) && !s_waitrequest && s_write;
      accept_rd = (state == IDLE) && !s_waitrequest && s_read && !s_write;
   end

   // The RAM output is already a register, so read data passes straight through
   // and lines up with the registered readdatavalid one cycle after each issue.
   assign s_readdata = ram_readdata;

   // NOTE: non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         addr            <= '0;
         addr_wrapped    <= 1'b0;
         beats_left      <= '0;
         s_waitrequest   <= 1'b1;
         s_readdatavalid <= 1'b0;
         ram_address     <= '0;
         ram_byteenable  <= '0;
         ram_chipselect  <= 1'b0;
         ram_write       <= 1'b0;
         ram_writedata   <= '0;
         ram_clken       <= 1'b0;
         wrap_flag       <= 1'b0;
      end else begin
         ram_clken       <= 1'b1;
         ram_chipselect  <= 1'b0;
         ram_write       <= 1'b0;
         wrap_flag       <= 1'b0;
         s_readdatavalid <= ram_chipselect && !ram_write;

         unique case (state)
            IDLE: begin
               s_waitrequest <= 1'b0;
               if (accept_wr) begin
                  ram_chipselect <= 1'b1;
                  ram_write      <= 1'b1;
                  ram_address    <= s_address;
                  ram_writedata  <= s_writedata;
                  ram_byteenable <= s_byteenable;
                  addr           <= next_addr(s_address);
                  addr_wrapped   <= (s_address == LAST_ADDR);
                  beats_left     <= req_count - BURST_W'(1);
                  if (req_count != BURST_W'(1)) begin
                     state <= WR;
                  end
               end else if (accept_rd) begin
                  ram_chipselect <= 1'b1;
                  ram_address    <= s_address;
                  ram_byteenable <= '1;
                  addr           <= next_addr(s_address);
                  addr_wrapped   <= (s_address == LAST_ADDR);
                  beats_left     <= req_count - BURST_W'(1);
                  s_waitrequest  <= 1'b1;
                  state          <= RD;
               end
            end

            RD: begin
               if (beats_left != '0) begin
                  ram_chipselect <= 1'b1;
                  ram_address    <= addr;
                  ram_byteenable <= '1;
                  wrap_flag      <= addr_wrapped;
                  addr           <= next_addr(addr);
                  addr_wrapped   <= (addr == LAST_ADDR);
                  beats_left     <= beats_left - BURST_W'(1);
               end else if (!ram_chipselect) begin
                  // last read data is on its way back this cycle; reopen after it
                  s_waitrequest <= 1'b0;
                  state         <= IDLE;
               end
            end

            WR: begin
               if (s_write) begin
                  ram_chipselect <= 1'b1;
                  ram_write      <= 1'b1;
                  ram_address    <= addr;
                  ram_writedata  <= s_writedata;
                  ram_byteenable <= s_byteenable;
                  wrap_flag      <= addr_wrapped;
                  addr           <= next_addr(addr);
                  addr_wrapped   <= (addr == LAST_ADDR);
                  beats_left     <= beats_left - BURST_W'(1);
                  if (beats_left == BURST_W'(1)) begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/onchip_ram_burst_adapter.md
Name: onchip_ram_burst_adapter

Overview:
- Avalon-MM burst slave placed directly upstream of the 12288 x 32 single-port on-chip RAM.
- Accepts read and write bursts from the system interconnect.
- Issues them to the RAM as one single-word access per cycle, with incrementing addresses.
- Returns read data with readdatavalid, compensating for the RAM's fixed 1-cycle read latency.

Parameters:
- ADDR_W, 14, word-address width on both sides
- DATA_W, 32, data width; byteenable width is DATA_W/8
- BURST_W, 4, burstcount width; legal bursts are 1..15 words
- DEPTH, 12288, number of RAM words; addresses wrap at DEPTH

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- s_address  in  ADDR_W  burst start word address
- s_burstcount  in  BURST_W  burst length in words
- s_read  in  1  read request
- s_write  in  1  write request / write beat
- s_writedata  in  DATA_W  write beat data
- s_byteenable  in  DATA_W/8  byte lanes for the write beat
- s_waitrequest  out  1  stall; request or beat is accepted when its strobe is high and this is low
- s_readdata  out  DATA_W  read beat data
- s_readdatavalid  out  1  s_readdata valid this cycle
- ram_address  out  ADDR_W  RAM word address
- ram_byteenable  out  DATA_W/8  RAM byte lanes
- ram_chipselect  out  1  RAM access strobe
- ram_write  out  1  RAM write strobe
- ram_writedata  out  DATA_W  RAM write data
- ram_clken  out  1  RAM clock enable; driven to 1 out of reset
- ram_readdata  in  DATA_W  RAM output; valid the cycle after a read address is presented
- wrap_flag  out  1  one-cycle pulse when a burst address wraps from DEPTH-1 to 0

Behaviour:
- All outputs are registered.
- Reset values:
  - s_waitrequest=1; ram_clken=0.
  - All other outputs are 0; FSM is in IDLE.
  - In the first cycle after reset deasserts: s_waitrequest=0 and ram_clken=1.
- FSM states: IDLE, RD, WR.
- IDLE (s_waitrequest=0):
  - s_write accepted: latch address and count, then move to WR.
    - Count is s_burstcount; a burstcount of 0 is treated as 1.
    - The next cycle, drive ram_chipselect=ram_write=1 with the latched address, data and byteenable.
    - If count==1, return to IDLE instead of WR.
  - s_read accepted (and s_write low): latch address and count, then move to RD.
  - s_read and s_write both high: the write wins; the read is ignored.
- RD (s_waitrequest=1 for the whole burst):
  - Issue one read per cycle: ram_chipselect=1, ram_write=0, addresses base, base+1, ...
  - s_readdatavalid=1 with s_readdata=ram_readdata exactly 1 cycle after each issue.
  - Timing for an accept at cycle T:
    - First RAM address at T+1.
    - First readdatavalid at T+2.
    - Last readdatavalid at T+1+n.
  - Return to IDLE so that s_waitrequest=0 in cycle T+2+n.
- WR (s_waitrequest=0):
  - Each accepted s_write beat is written to the RAM the following cycle at the next incremented address.
  - Cycles with no beat produce no RAM strobe.
  - After the n-th beat is accepted, return to IDLE.
  - s_read in WR is ignored and not accepted.
- Address arithmetic:
  - next = (addr==DEPTH-1) ? 0 : addr+1.
  - On wrap, wrap_flag pulses for 1 cycle, aligned with the RAM access at address 0.
- ram_byteenable is 4'hF for reads.
- Reset mid-burst: returns to IDLE immediately. Remaining beats are dropped, with no further RAM strobes or readdatavalid.

Test Plan:
- Single write: addr 0x0010, data 0xDEADBEEF, be 0xF, burst 1 → one cycle with ram_write=1 at 0x0010. A following burst-1 read → readdatavalid 2 cycles after accept, data 0xDEADBEEF.
- Write burst of 4 at 0x0100 with data 1..4, including one idle gap between beats 2 and 3 → RAM writes at 0x100..0x103, no strobe in the gap cycle, FSM back in IDLE.
- Read burst of 8 at 0x0100 → 8 consecutive readdatavalid cycles, starting 2 cycles after accept. s_waitrequest stays high until the last beat.
- Wrap: read burst of 3 at 0x2FFF → RAM addresses 0x2FFF, 0x0000, 0x0001, with wrap_flag pulsing on the 0x0000 cycle.
- Byte enables: write 0xAABBCCDD with be 0x5 over existing 0x11223344 → readback 0x11BB33DD. Burstcount 0 → treated as a single beat.
- Reset asserted on the 3rd beat of a read burst of 8 → no further readdatavalid. s_waitrequest=1 during reset and 0 the cycle after; a new burst then completes normally.
